bcd_counter_scanner: RTL

- Multi-digit synchronous BCD up/down counter with a digit scanner that presents one BCD digit per transfer, least significant digit first.
- Sits directly upstream of the BCD-to-Excess-3 converter: dig_out drives the converter's 4-bit BCD input.
- Always emits legal BCD codes 0-9, so the converter never sees 1010-1111.

---
 rtl/bcd_counter_scanner.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_scanner.sv
// Multi-digit BCD up/down counter with a least-significant-first digit scanner.
// The scanner emits a snapshot of the count taken when the scan starts, so later
// loads and counting do not change the digits of a scan in progress.
// Every digit presented on dig_out is a legal BCD code (0-9).
module bcd_counter_scanner #(
    parameter int unsigned NDIG = 4,
    parameter int unsigned IW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] cnt,
    output logic              tc,
    output logic              ld_err,
    input  logic              start,
    output logic              busy,
    output logic [3:0]        dig_out,
    output logic [IW-1:0]     dig_idx,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic              done
);

    localparam int unsigned W = 4 * NDIG;
    localparam logic [IW-1:0] LastIdx = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    // Counter state
    logic [W-1:0]  cnt_q, cnt_d;
    logic          ld_err_q, ld_err_d;

    // Counter helpers
    logic [W-1:0]  load_clean;
    logic          load_bad;
    logic [W-1:0]  cnt_inc;
    logic [W-1:0]  cnt_dec;
    logic          all_nine;
    logic          all_zero;

    // Scanner state
    state_e        state_q, state_d;
    logic [W-1:0]  snap_q, snap_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    dig_sel;

    // Replace any non-BCD nibble of load_val by 0 and flag it.
    always_comb begin
        load_clean = load_val;
        load_bad   = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
                load_bad             = 1'b1;
            end
        end
    end

    // Detect the all-nines and all-zeros terminal values.
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (cnt_q[4*i +: 4] != 4'd9) begin
                all_nine = 1'b0;
            end
            if (cnt_q[4*i +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
        end
    end

    // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        cnt_inc = cnt_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Ripple BCD decrement: a 0 rolls to 9 and passes the borrow upward.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        cnt_dec = cnt_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Counter next state: load beats enable, enable beats hold.
    always_comb begin
        cnt_d    = cnt_q;
        ld_err_d = 1'b0;
        if (load) begin
            cnt_d    = load_clean;
            ld_err_d = load_bad;
        end else if (en) begin
            cnt_d = up ? cnt_inc : cnt_dec;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Scanner next state; a start is only honoured from idle.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d  = cnt_q;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (dig_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scanner registers; reset aborts a scan without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            snap_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    // Select the snapshot digit addressed by the current index.
    always_comb begin
        dig_sel = 4'd0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == IW'(i)) begin
                dig_sel = snap_q[4*i +: 4];
            end
        end
    end

    // Outputs decoded from registered state only (tc excepted).
    always_comb begin
        cnt       = cnt_q;
        ld_err    = ld_err_q;
        tc        = en & ~load & (up ? all_nine : all_zero);
        busy      = (state_q != StIdle);
        dig_valid = (state_q == StSend);
        dig_out   = (state_q == StSend) ? dig_sel : 4'd0;
        dig_idx   = idx_q;
        done      = (state_q == StDone);
    end

endmodule
